and_gate_test_ctrl: RTL and testbench

AND_GATE_TEST_CTRL -- requirements
Module: and_gate_test_ctrl

---
 rtl/and_gate_test_ctrl.sv | 138 +++++++++++++
 tb/tb_and_gate_test_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/and_gate_test_ctrl.sv
// Self-test sequencer for a 2-input AND gate: applies 00,01,10,11 for HOLD_CYCLES each,
// samples the gate output at the end of each hold window and reports mismatch statistics.
module and_gate_test_ctrl #(
  parameter int HOLD_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  input  logic       dut_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic       fail_valid,
  output logic [1:0] first_fail_vec
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(HOLD_CYCLES - 1);

  state_t     state_r;
  logic [1:0] v_r;
  logic [7:0] cnt_r;

  logic       mismatch_s;
  logic       last_hold_s;
  logic [2:0] err_next_s;
  logic [1:0] v_next_s;

  // Sample-edge decode; err_next_s already includes the mismatch being sampled now.
  always_comb begin
    mismatch_s  = 1'b0;
    last_hold_s = 1'b0;
    err_next_s  = err_count;
    v_next_s    = v_r + 2'd1;
    if (state_r == ST_RUN) begin
      mismatch_s  = (dut_y != (dut_a & dut_b));
      last_hold_s = (cnt_r == LAST_CNT);
      err_next_s  = err_count + {2'b00, mismatch_s};
    end else begin
      mismatch_s  = 1'b0;
      last_hold_s = 1'b0;
      err_next_s  = err_count;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      v_r            <= 2'd0;
      cnt_r          <= 8'd0;
      dut_a          <= 1'b0;
      dut_b          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= 3'd0;
      fail_valid     <= 1'b0;
      first_fail_vec <= 2'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done  <= 1'b0;
          dut_a <= 1'b0;
          dut_b <= 1'b0;
          if (start) begin
            state_r        <= ST_RUN;
            v_r            <= 2'd0;
            cnt_r          <= 8'd0;
            busy           <= 1'b1;
            pass           <= 1'b0;
            err_count      <= 3'd0;
            fail_valid     <= 1'b0;
            first_fail_vec <= 2'd0;
          end else begin
            busy <= 1'b0;
          end
        end

        ST_RUN: begin
          if (last_hold_s) begin
            cnt_r <= 8'd0;
            if (mismatch_s) begin
              err_count <= err_next_s;
              if (!fail_valid) begin
                fail_valid     <= 1'b1;
                first_fail_vec <= {dut_a, dut_b};
              end
            end
            // Final vector: leave RUN with the gate inputs parked at 0.
            if (v_r == 2'd3) begin
              state_r <= ST_DONE;
              v_r     <= 2'd0;
              busy    <= 1'b0;
              done    <= 1'b1;
              dut_a   <= 1'b0;
              dut_b   <= 1'b0;
              pass    <= (err_next_s == 3'd0);
            end else begin
              v_r   <= v_next_s;
              dut_a <= v_next_s[1];
              dut_b <= v_next_s[0];
            end
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end

        ST_DONE: begin
          state_r <= ST_IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
          dut_a   <= 1'b0;
          dut_b   <= 1'b0;
        end

        default: begin
          state_r <= ST_IDLE;
          v_r     <= 2'd0;
          cnt_r   <= 8'd0;
          busy    <= 1'b0;
          done    <= 1'b0;
          dut_a   <= 1'b0;
          dut_b   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_and_gate_test_ctrl.sv
// Randomized self-checking bench: the gate under test is a 4-entry truth table indexed by {a,b};
// expected results are derived directly from that table.
module tb_and_gate_test_ctrl;

  localparam int HOLD = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       dut_a, dut_b, dut_y, busy, done, pass, fail_valid;
  logic [2:0] err_count;
  logic [1:0] first_fail_vec;
  logic [3:0] gate_tt = 4'b1000;

  logic       start2 = 1'b0;
  logic       a2, b2, y2, busy2, done2, pass2, fv2;
  logic [2:0] err2;
  logic [1:0] ffv2;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  assign dut_y = gate_tt[{dut_a, dut_b}];
  assign y2    = a2 & b2;

  and_gate_test_ctrl #(.HOLD_CYCLES(HOLD)) u_dut (
    .clk(clk), .rst(rst), .start(start), .dut_a(dut_a), .dut_b(dut_b), .dut_y(dut_y),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fail_valid), .first_fail_vec(first_fail_vec)
  );

  and_gate_test_ctrl #(.HOLD_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .dut_a(a2), .dut_b(b2), .dut_y(y2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_valid(fv2), .first_fail_vec(ffv2)
  );

  // Checks one full run; entered at the first falling edge after start was accepted,
  // leaves at the falling edge after the DONE cycle.
  task automatic do_run(input logic [3:0] tt, input string tag);
    int n;
    int exp_errs;
    int exp_mid;
    int exp_first;
    bit exp_fv;
    exp_errs = 0; exp_first = 0; exp_fv = 0;
    for (int v = 0; v < 4; v++) begin
      if (tt[v] != (v == 3)) begin
        if (!exp_fv) exp_first = v;
        exp_fv = 1;
        exp_errs++;
      end
    end
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      if (n < 4 * HOLD) begin
        exp_mid = 0;
        for (int v = 0; v < n / HOLD; v++) if (tt[v] != (v == 3)) exp_mid++;
        n_total++;
        if ({dut_a, dut_b} !== 2'(n / HOLD) || err_count !== 3'(exp_mid)) begin
          $display("FAIL %s vec/err cyc=%0d: ab=%b err=%0d, expected ab=%b err=%0d",
                   tag, n, {dut_a, dut_b}, err_count, 2'(n / HOLD), exp_mid);
        end else n_pass++;
      end
      @(negedge clk);
      n++;
    end
    n_total++;
    if (n !== 4 * HOLD) $display("FAIL %s busy_len: %0d cycles, expected %0d", tag, n, 4 * HOLD);
    else n_pass++;
    n_total++;
    if (done !== 1'b1 || pass !== (exp_errs == 0) || err_count !== 3'(exp_errs) ||
        fail_valid !== exp_fv || (exp_fv && first_fail_vec !== 2'(exp_first)) ||
        dut_a !== 1'b0 || dut_b !== 1'b0) begin
      $display("FAIL %s result: done=%b pass=%b err=%0d fv=%b ffv=%b ab=%b%b, expected done=1 pass=%b err=%0d fv=%b ffv=%0d ab=00",
               tag, done, pass, err_count, fail_valid, first_fail_vec, dut_a, dut_b,
               exp_errs == 0, exp_errs, exp_fv, exp_first);
    end else n_pass++;
    @(negedge clk);
    n_total++;
    if (done !== 1'b0 || busy !== 1'b0 || err_count !== 3'(exp_errs) || pass !== (exp_errs == 0)) begin
      $display("FAIL %s post_done: done=%b busy=%b err=%0d pass=%b, expected done=0 busy=0 err=%0d pass=%b",
               tag, done, busy, err_count, pass, exp_errs, exp_errs == 0);
    end else n_pass++;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_total++;
    if ({dut_a, dut_b, busy, done, pass, err_count, fail_valid, first_fail_vec} !== 11'd0 ||
        {a2, b2, busy2, done2, pass2, err2, fv2, ffv2} !== 11'd0)
      $display("FAIL reset_state: dut=%b dut2=%b, expected all zero",
               {dut_a, dut_b, busy, done, pass, err_count, fail_valid, first_fail_vec},
               {a2, b2, busy2, done2, pass2, err2, fv2, ffv2});
    else n_pass++;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_gate(input logic [3:0] tt, input string tag);
    gate_tt = tt;
    pulse_start();
    do_run(tt, tag);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      logic [3:0] tt;
      tt = 4'($urandom_range(0, 15));
      test_gate(tt, $sformatf("rand%0d_tt%b", k, tt));
    end
  endtask

  task automatic test_hold2();
    logic [1:0] seq [$];
    int n;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    n = 0;
    while (busy2 === 1'b1 && n < 100) begin
      seq.push_back({a2, b2});
      @(negedge clk);
      n++;
    end
    n_total++;
    if (seq.size() != 8) $display("FAIL hold2_len: %0d busy cycles, expected 8", seq.size());
    else n_pass++;
    for (int i = 0; i < seq.size() && i < 8; i++) begin
      n_total++;
      if (seq[i] !== 2'(i / 2)) $display("FAIL hold2_seq[%0d]: %b, expected %b", i, seq[i], 2'(i / 2));
      else n_pass++;
    end
    n_total++;
    if (done2 !== 1'b1 || a2 !== 1'b0 || b2 !== 1'b0 || pass2 !== 1'b1 || err2 !== 3'd0)
      $display("FAIL hold2_done: done=%b ab=%b%b pass=%b err=%0d, expected done=1 ab=00 pass=1 err=0",
               done2, a2, b2, pass2, err2);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int n;
    gate_tt = 4'b1111;
    pulse_start();
    for (int i = 0; i < 15; i++) @(negedge clk);
    n_total++;
    if (busy !== 1'b1 || err_count !== 3'd1 || fail_valid !== 1'b1 || {dut_a, dut_b} !== 2'b01)
      $display("FAIL midrun_state: busy=%b err=%0d fv=%b ab=%b%b, expected busy=1 err=1 fv=1 ab=01",
               busy, err_count, fail_valid, dut_a, dut_b);
    else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_total++;
    if ({dut_a, dut_b, busy, done, pass, err_count, fail_valid, first_fail_vec} !== 11'd0)
      $display("FAIL async_reset: outputs=%b, expected all zero",
               {dut_a, dut_b, busy, done, pass, err_count, fail_valid, first_fail_vec});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) n++;
    end
    n_total++;
    if (n != 0) $display("FAIL reset_abort: %0d cycles with done/busy, expected 0", n);
    else n_pass++;
    test_gate(4'b1000, "post_reset");
  endtask

  task automatic test_back_to_back();
    gate_tt = 4'b1111;
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    do_run(4'b1111, "b2b_first");
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL b2b_idle_gap: busy=%b done=%b, expected 0 0", busy, done);
    else n_pass++;
    gate_tt = 4'b1000;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b1 || err_count !== 3'd0 || fail_valid !== 1'b0 || pass !== 1'b0)
      $display("FAIL b2b_restart: busy=%b err=%0d fv=%b pass=%b, expected busy=1 err=0 fv=0 pass=0",
               busy, err_count, fail_valid, pass);
    else n_pass++;
    start = 1'b0;
    do_run(4'b1000, "b2b_second");
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || pass !== 1'b1)
      $display("FAIL b2b_stop: busy=%b pass=%b, expected busy=0 pass=1", busy, pass);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_gate(4'b1000, "and_gate");
    test_gate(4'b1111, "stuck_at_1");
    test_gate(4'b1110, "or_gate");
    test_gate(4'b0000, "stuck_at_0");
    test_random();
    test_hold2();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
